y86_instr_encoder: RTL

Write-side counterpart of the SEQ fetch stage. Accepts one decoded Y86-64 instruction per handshake as icode, ifun, rA, rB and valC. Serialises it into the canonical 1/2/9/10-byte encoding and writes it byte-by-byte into instruction memory at a running write PC. Used by the bench and boot loader to build program images that fetch then reads back.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/y86_instr_pack.sv | 36 +++
 rtl/y86_instr_encoder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the "no register" marker
// and the encoded length of each instruction class.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int IMG_BYTES = 10;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } enc_state_e;

  // Encoded length in bytes; 0 marks an icode with no encoding.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:                 instr_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     instr_len = 4'd2;
      I_JXX, I_CALL:                        instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         instr_len = 4'd10;
      default:                              instr_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_pack.sv
// Combinational packer: turns decoded instruction fields into the byte image
// that memory should hold, byte 0 in image[7:0], valC little-endian.
module y86_instr_pack
  import y86_pkg::*;
(
  input  logic [3:0]              icode,
  input  logic [3:0]              ifun,
  input  logic [3:0]              rA,
  input  logic [3:0]              rB,
  input  logic [63:0]             valC,
  output logic [8*IMG_BYTES-1:0]  image,
  output logic [3:0]              len
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    image      = '0;
    len        = instr_len(icode);
    image[7:0] = {icode, ifun};
    case (icode)
      I_RRMOVQ, I_OPQ: image[15:8] = {rA, rB};
      I_PUSHQ, I_POPQ: image[15:8] = {rA, RNONE};
      I_IRMOVQ: begin
        image[15:8]  = {RNONE, rB};
        image[79:16] = valC;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        image[15:8]  = {rA, rB};
        image[79:16] = valC;
      end
      I_JXX, I_CALL: image[71:8] = valC;
      default: ;
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction per handshake into instruction
// memory, one byte per accepted write, advancing a running write PC.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int unsigned PC_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_wready,
  output logic              instr_done,
  output logic              err_icode,
  output logic [ADDR_W-1:0] wr_pc
);

  localparam int IMG_W = 8 * IMG_BYTES;

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_pc_q, wr_pc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [IMG_W-1:0]  image_q, image_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        len_q, len_d;
  logic              err_icode_q, err_icode_d;

  logic [IMG_W-1:0]  pack_image;
  logic [3:0]        pack_len;

  y86_instr_pack u_pack (
    .icode (icode),
    .ifun  (ifun),
    .rA    (rA),
    .rB    (rB),
    .valC  (valC),
    .image (pack_image),
    .len   (pack_len)
  );

  always_comb begin
    state_d     = state_q;
    wr_pc_d     = wr_pc_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    image_d     = image_q;
    idx_d       = idx_q;
    len_d       = len_q;
    err_icode_d = 1'b0;
    instr_done  = 1'b0;
    in_ready    = (state_q == S_IDLE) && !load_pc;

    case (state_q)
      S_IDLE: begin
        if (load_pc) begin
          wr_pc_d = pc_load_val;
        end else if (in_valid) begin
          if (pack_len == 4'd0) begin
            err_icode_d = 1'b1;
          end else begin
            // image_q keeps only the bytes still to be put on the bus.
            state_d     = S_EMIT;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_pc_q;
            mem_wdata_d = pack_image[7:0];
            image_d     = {8'h00, pack_image[IMG_W-1:8]};
            idx_d       = 4'd0;
            len_d       = pack_len;
          end
        end
      end
      S_EMIT: begin
        if (load_pc) begin
          wr_pc_d  = pc_load_val;
          mem_we_d = 1'b0;
          state_d  = S_IDLE;
        end else if (mem_wready) begin
          if (idx_q == len_q - 4'd1) begin
            instr_done = 1'b1;
            mem_we_d   = 1'b0;
            wr_pc_d    = wr_pc_q + ADDR_W'(len_q);
            state_d    = S_IDLE;
          end else begin
            idx_d       = idx_q + 4'd1;
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_wdata_d = image_q[7:0];
            image_d     = {8'h00, image_q[IMG_W-1:8]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_pc_q     <= ADDR_W'(PC_INIT);
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      image_q     <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      err_icode_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      wr_pc_q     <= wr_pc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      image_q     <= image_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      err_icode_q <= err_icode_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_icode = err_icode_q;
  assign wr_pc     = wr_pc_q;

endmodule
